rom_loader: RTL and testbench

// - Boot-time sequencer that drives the spi byte engine to copy cartridge ROM from SPI flash into program RAM.
// - Issues flash READ (0x03 + 24-bit address), streams LOAD_BYTES bytes and writes each one to RAM.
// - Holds the CPU in halt and publishes a page progress count on load_count for the peripherals register 0x13.
// - Sits between the top level, the spi instance, and the RAM write port. Owns the SPI bus while busy=1.

---
 rtl/rom_loader.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_rom_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader
// Description : Boot-time sequencer that drives an SPI byte engine to copy
//               cartridge ROM from SPI flash into program RAM. It issues a
//               flash READ (0x03 + 24-bit address), then streams LOAD_BYTES
//               bytes and writes each one to RAM. busy doubles as the CPU
//               halt request. load_count reports completed 256-byte pages.
// Optional    : ROM_LOADER_CHECKSUM_EN -- when defined, checksum is the 8-bit
//               modular sum of the bytes written during the current load.
//               When undefined, checksum is tied to 8'h00 and no adder is built.
// Ports       : raw_clk, reset (async, active-high)
//               start            - one-cycle pulse, starts a load when idle
//               busy/done/error  - status (done, error sticky until start)
//               spi_start, spi_data_tx, spi_data_rx, spi_busy,
//               spi_cs, spi_divisor - SPI engine / flash interface
//               mem_address, mem_data, mem_write_enable - RAM write port
//               load_count       - completed pages, saturating at 255
//               checksum         - see Optional above
// Revision    : 1.0 - initial release
// ============================================================================
module rom_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          LOAD_BYTES = 4096,
  parameter logic [23:0] FLASH_BASE = 24'h0,
  parameter logic [2:0]  SPI_DIV    = 3'd1,
  parameter int          TIMEOUT    = 1023
) (
  input  logic                  raw_clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  spi_start,
  output logic [7:0]            spi_data_tx,
  input  logic [7:0]            spi_data_rx,
  input  logic                  spi_busy,
  output logic                  spi_cs,
  output logic [2:0]            spi_divisor,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_data,
  output logic                  mem_write_enable,
  output logic [7:0]            load_count,
  output logic [7:0]            checksum
);

  // Byte counter needs at least 9 bits so bits [7:0] always exist for page detection.
  localparam int c_cnt_raw = $clog2(LOAD_BYTES + 1);
  localparam int c_cnt_w   = (c_cnt_raw > 9) ? c_cnt_raw : 9;
  // Timer is shared by the CS setup hold (needs to reach 2) and the spi_busy timeout.
  localparam int c_tmr_raw = $clog2(TIMEOUT + 1);
  localparam int c_tmr_w   = (c_tmr_raw > 2) ? c_tmr_raw : 2;

  localparam logic [c_cnt_w-1:0]    c_load_bytes   = c_cnt_w'(LOAD_BYTES);
  localparam logic [c_cnt_w-1:0]    c_cnt_one      = c_cnt_w'(1);
  localparam logic [c_tmr_w-1:0]    c_tmr_one      = c_tmr_w'(1);
  localparam logic [c_tmr_w-1:0]    c_tmr_cs_hold  = c_tmr_w'(2);
  localparam logic [c_tmr_w-1:0]    c_tmr_last     = c_tmr_w'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_one     = ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CS_LOW  = 4'd1,
    S_CMD     = 4'd2,
    S_A2      = 4'd3,
    S_A1      = 4'd4,
    S_A0      = 4'd5,
    S_READ    = 4'd6,
    S_WRITE   = 4'd7,
    S_CS_HIGH = 4'd8,
    S_FAULT   = 4'd9
  } state_t;

  state_t                  state_q, state_d;
  logic                    phase_q, phase_d;   // 0: requesting spi_start, 1: waiting for spi_busy to fall
  logic [c_tmr_w-1:0]      tmr_q, tmr_d;
  logic [c_cnt_w-1:0]      cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    spi_start_q, spi_start_d;
  logic [7:0]              spi_tx_q, spi_tx_d;
  logic                    spi_cs_q, spi_cs_d;
  logic [2:0]              spi_div_q, spi_div_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              mem_data_q, mem_data_d;
  logic                    mem_we_q, mem_we_d;
  logic [7:0]              load_count_q, load_count_d;

  logic                    start_accept;
  logic                    rx_capture;
  logic [c_cnt_w-1:0]      cnt_next;

  assign start_accept = (state_q == S_IDLE) && start;
  // The received byte is valid in the cycle spi_busy is seen low after the READ transfer.
  assign rx_capture   = (state_q == S_READ) && phase_q && !spi_busy;
  assign cnt_next     = cnt_q + c_cnt_one;

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      tmr_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      spi_start_q  <= 1'b0;
      spi_tx_q     <= 8'h00;
      spi_cs_q     <= 1'b1;
      spi_div_q    <= 3'd0;
      addr_q       <= '0;
      mem_data_q   <= 8'h00;
      mem_we_q     <= 1'b0;
      load_count_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      tmr_q        <= tmr_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      spi_start_q  <= spi_start_d;
      spi_tx_q     <= spi_tx_d;
      spi_cs_q     <= spi_cs_d;
      spi_div_q    <= spi_div_d;
      addr_q       <= addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      load_count_q <= load_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    tmr_d        = tmr_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    spi_start_d  = spi_start_q;
    spi_tx_d     = spi_tx_q;
    spi_cs_d     = spi_cs_q;
    spi_div_d    = spi_div_q;
    addr_d       = addr_q;
    mem_data_d   = mem_data_q;
    mem_we_d     = 1'b0;
    load_count_d = load_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_CS_LOW;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          cnt_d        = '0;
          addr_d       = '0;
          load_count_d = 8'h00;
          tmr_d        = '0;
        end
      end

      S_CS_LOW: begin
        spi_cs_d  = 1'b0;
        spi_div_d = SPI_DIV;
        // Two full cycles of chip select low before the command byte is requested.
        if (tmr_q == c_tmr_cs_hold) begin
          state_d     = S_CMD;
          spi_tx_d    = 8'h03;
          spi_start_d = 1'b1;
          phase_d     = 1'b0;
          tmr_d       = '0;
        end else begin
          tmr_d = tmr_q + c_tmr_one;
        end
      end

      S_CMD, S_A2, S_A1, S_A0, S_READ: begin
        if (!phase_q) begin
          if (spi_busy) begin
            spi_start_d = 1'b0;
            phase_d     = 1'b1;
          end else if (tmr_q == c_tmr_last) begin
            state_d = S_FAULT;
          end else begin
            tmr_d = tmr_q + c_tmr_one;
          end
        end else if (!spi_busy) begin
          phase_d = 1'b0;
          tmr_d   = '0;
          case (state_q)
            S_CMD: begin
              state_d     = S_A2;
              spi_tx_d    = FLASH_BASE[23:16];
              spi_start_d = 1'b1;
            end
            S_A2: begin
              state_d     = S_A1;
              spi_tx_d    = FLASH_BASE[15:8];
              spi_start_d = 1'b1;
            end
            S_A1: begin
              state_d     = S_A0;
              spi_tx_d    = FLASH_BASE[7:0];
              spi_start_d = 1'b1;
            end
            S_A0: begin
              state_d     = S_READ;
              spi_tx_d    = 8'h00;
              spi_start_d = 1'b1;
            end
            default: begin
              state_d    = S_WRITE;
              mem_data_d = spi_data_rx;
              mem_we_d   = 1'b1;
            end
          endcase
        end
      end

      S_WRITE: begin
        // mem_write_enable is high during this cycle with the current address.
        addr_d = addr_q + c_addr_one;
        cnt_d  = cnt_next;
        if ((cnt_next[7:0] == 8'h00) && (load_count_q != 8'hFF)) begin
          load_count_d = load_count_q + 8'd1;
        end
        if (cnt_next == c_load_bytes) begin
          state_d = S_CS_HIGH;
        end else begin
          state_d     = S_READ;
          spi_tx_d    = 8'h00;
          spi_start_d = 1'b1;
          phase_d     = 1'b0;
          tmr_d       = '0;
        end
      end

      S_CS_HIGH: begin
        spi_cs_d  = 1'b1;
        spi_div_d = 3'd0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end

      S_FAULT: begin
        spi_cs_d    = 1'b1;
        spi_start_d = 1'b0;
        spi_div_d   = 3'd0;
        busy_d      = 1'b0;
        error_d     = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_accept) begin
      checksum_d = 8'h00;
    end else if (rx_capture) begin
      checksum_d = checksum_q + spi_data_rx;
    end
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      checksum_q <= 8'h00;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 8'h00;
`endif

  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign spi_start        = spi_start_q;
  assign spi_data_tx      = spi_tx_q;
  assign spi_cs           = spi_cs_q;
  assign spi_divisor      = spi_div_q;
  assign mem_address      = addr_q;
  assign mem_data         = mem_data_q;
  assign mem_write_enable = mem_we_q;
  assign load_count       = load_count_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rom_loader
// Description : Self-checking bench for rom_loader with a behavioural SPI
//               engine / flash model and queue-based scoreboard for MOSI bytes
//               and RAM writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

  localparam int          LB   = 512;
  localparam logic [23:0] BASE = 24'h010203;
  localparam int          TO   = 1023;
  localparam logic [2:0]  DIV  = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error, spi_start, spi_cs, mem_we;
  logic [7:0]  spi_data_tx, mem_data, load_count, checksum;
  logic [7:0]  spi_data_rx = 8'h00;
  logic        spi_busy = 1'b0;
  logic [2:0]  spi_divisor;
  logic [11:0] mem_address;

  always #5 clk = ~clk;

  rom_loader #(
    .ADDR_WIDTH (12),
    .LOAD_BYTES (LB),
    .FLASH_BASE (BASE),
    .SPI_DIV    (DIV),
    .TIMEOUT    (TO)
  ) dut (
    .raw_clk          (clk),
    .reset            (rst),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .spi_start        (spi_start),
    .spi_data_tx      (spi_data_tx),
    .spi_data_rx      (spi_data_rx),
    .spi_busy         (spi_busy),
    .spi_cs           (spi_cs),
    .spi_divisor      (spi_divisor),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .mem_write_enable (mem_we),
    .load_count       (load_count),
    .checksum         (checksum)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_wr[$];
  logic [7:0] flash[LB];
  logic [7:0] ram[4096];
  logic [7:0] exp_sum;
  int         wr_cnt = 0;
  bit         no_resp = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // SPI engine + flash model: runs on the falling edge so DUT inputs change away from posedge.
  int         m_cnt = 0;
  int         bidx = 0;
  logic [7:0] m_rx = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      spi_busy = 1'b0;
      m_cnt    = 0;
      bidx     = 0;
    end else begin
      if (spi_cs) bidx = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          spi_busy    = 1'b0;
          spi_data_rx = m_rx;
        end
      end else if (spi_start && !spi_busy && !no_resp) begin
        check_value("mosi_expected", 32'(exp_mosi.size() != 0), 32'd1);
        if (exp_mosi.size() != 0) check_value("mosi_byte", 32'(spi_data_tx), 32'(exp_mosi.pop_front()));
        check_value("cs_low_during_xfer", 32'(spi_cs), 32'd0);
        m_rx     = (bidx >= 4 && (bidx - 4) < LB) ? flash[bidx-4] : 8'h00;
        bidx++;
        spi_busy = 1'b1;
        m_cnt    = 2;
      end
    end
  end

  // RAM write monitor.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      ram[mem_address] = mem_data;
      check_value("we_one_cycle", 32'(prev_we), 32'd0);
      check_value("wr_addr", 32'(mem_address), 32'(wr_cnt % 4096));
      check_value("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) check_value("wr_data", 32'(mem_data), 32'(exp_wr.pop_front()));
      check_value("load_count_step", 32'(load_count), 32'(wr_cnt / 256));
      wr_cnt++;
    end
    prev_we = rst ? 1'b0 : mem_we;
  end

  task automatic pulse_start(input bit push);
    if (push) begin
      exp_mosi.delete();
      exp_wr.delete();
      exp_mosi.push_back(8'h03);
      exp_mosi.push_back(BASE[23:16]);
      exp_mosi.push_back(BASE[15:8]);
      exp_mosi.push_back(BASE[7:0]);
      exp_sum = 8'h00;
      for (int i = 0; i < LB; i++) begin
        exp_mosi.push_back(8'h00);
        exp_wr.push_back(flash[i]);
        exp_sum = exp_sum + flash[i];
      end
      wr_cnt = 0;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int bound, output int cycles);
    cycles = 0;
    while (!(done || error) && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
    check_value("wait_end_in_time", 32'(done || error), 32'd1);
  endtask

  task automatic check_sum(input string tag);
`ifdef ROM_LOADER_CHECKSUM_EN
    check_value(tag, 32'(checksum), 32'(exp_sum));
`else
    check_value(tag, 32'(checksum), 32'd0);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int g;

    repeat (3) @(negedge clk);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_done", 32'(done), 32'd0);
    check_value("rst_error", 32'(error), 32'd0);
    check_value("rst_spi_start", 32'(spi_start), 32'd0);
    check_value("rst_spi_tx", 32'(spi_data_tx), 32'd0);
    check_value("rst_spi_cs", 32'(spi_cs), 32'd1);
    check_value("rst_divisor", 32'(spi_divisor), 32'd0);
    check_value("rst_mem_addr", 32'(mem_address), 32'd0);
    check_value("rst_mem_data", 32'(mem_data), 32'd0);
    check_value("rst_mem_we", 32'(mem_we), 32'd0);
    check_value("rst_load_count", 32'(load_count), 32'd0);
    check_value("rst_checksum", 32'(checksum), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Load 1: incrementing data.
    for (int i = 0; i < LB; i++) flash[i] = 8'(i);
    pulse_start(1'b1);
    check_value("busy_after_start", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check_value("divisor_while_busy", 32'(spi_divisor), 32'(DIV));
    check_value("cs_low_while_busy", 32'(spi_cs), 32'd0);
    wait_end(20000, cyc);
    check_value("l1_done", 32'(done), 32'd1);
    check_value("l1_error", 32'(error), 32'd0);
    check_value("l1_busy", 32'(busy), 32'd0);
    check_value("l1_cs", 32'(spi_cs), 32'd1);
    check_value("l1_divisor", 32'(spi_divisor), 32'd0);
    check_value("l1_load_count", 32'(load_count), 32'd2);
    check_value("l1_writes", 32'(wr_cnt), 32'(LB));
    check_value("l1_ram0", 32'(ram[0]), 32'h00);
    check_value("l1_ram3", 32'(ram[3]), 32'h03);
    check_value("l1_ram511", 32'(ram[511]), 32'hFF);
    check_value("l1_mosi_left", 32'(exp_mosi.size()), 32'd0);
    check_value("l1_wr_left", 32'(exp_wr.size()), 32'd0);
    check_sum("l1_checksum");

    // Timeout: engine never raises spi_busy.
    no_resp = 1'b1;
    exp_mosi.delete();
    exp_wr.delete();
    wr_cnt = 0;
    pulse_start(1'b0);
    check_value("to_done_cleared", 32'(done), 32'd0);
    wait_end(1100, cyc);
    check_value("to_error", 32'(error), 32'd1);
    check_value("to_not_late", 32'(cyc <= 1030), 32'd1);
    check_value("to_not_early", 32'(cyc >= 1000), 32'd1);
    check_value("to_cs", 32'(spi_cs), 32'd1);
    check_value("to_done", 32'(done), 32'd0);
    check_value("to_busy", 32'(busy), 32'd0);
    check_value("to_spi_start", 32'(spi_start), 32'd0);
    check_value("to_no_writes", 32'(wr_cnt), 32'd0);
    no_resp = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a load, after the first page has completed.
    for (int i = 0; i < LB; i++) flash[i] = 8'(i * 7 + 3);
    pulse_start(1'b1);
    check_value("rl_error_cleared", 32'(error), 32'd0);
    g = 0;
    while (wr_cnt < 300 && g < 10000) begin
      @(negedge clk);
      g++;
    end
    check_value("rl_reached_300", 32'(wr_cnt >= 300), 32'd1);
    check_value("rl_load_count_pre", 32'(load_count), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_value("rl_busy", 32'(busy), 32'd0);
    check_value("rl_cs", 32'(spi_cs), 32'd1);
    check_value("rl_load_count", 32'(load_count), 32'd0);
    check_value("rl_spi_start", 32'(spi_start), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_mosi.delete();
    exp_wr.delete();
    @(negedge clk);

    // Reload from byte 0, checksum pattern, with a second start while busy.
    for (int i = 0; i < LB; i++) flash[i] = 8'h00;
    flash[0] = 8'h80;
    flash[1] = 8'h90;
    flash[2] = 8'h05;
    pulse_start(1'b1);
    g = 0;
    while (wr_cnt < 10 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    pulse_start(1'b0);
    wait_end(20000, cyc);
    check_value("l2_done", 32'(done), 32'd1);
    check_value("l2_busy", 32'(busy), 32'd0);
    check_value("l2_writes", 32'(wr_cnt), 32'(LB));
    check_value("l2_ram0", 32'(ram[0]), 32'h80);
    check_value("l2_ram1", 32'(ram[1]), 32'h90);
    check_value("l2_ram2", 32'(ram[2]), 32'h05);
    check_value("l2_ram300", 32'(ram[300]), 32'h00);
    check_value("l2_load_count", 32'(load_count), 32'd2);
    check_value("l2_mosi_left", 32'(exp_mosi.size()), 32'd0);
    check_value("l2_wr_left", 32'(exp_wr.size()), 32'd0);
    check_sum("l2_checksum");
    repeat (5) @(negedge clk);
    check_value("l2_done_sticky", 32'(done), 32'd1);
    check_sum("l2_checksum_held");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
